pkt_demux: RTL and testbench
============================

PKT_DEMUX -- requirements
Module: pkt_demux

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of destination FIFOs (fixed power of two; address width $clog2(N_PORTS)).
REQ-002 SHALL have parameter DATA_W, default 8, byte width of the packet stream.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pkt_valid_i  input  1  upstream byte valid.
REQ-006 SHALL have port data_i  input  DATA_W  upstream byte.
REQ-007 SHALL have port ready_o  output  1  byte accepted this cycle when pkt_valid_i && ready_o.
REQ-008 SHALL have port fifo_full_i  input  N_PORTS  per-destination full flags from the FIFO pointer managers.
REQ-009 SHALL have port wr_o  output  N_PORTS  one-hot write strobes to destination FIFOs.
REQ-010 SHALL have port wr_data_o  output  DATA_W  write data, common to all FIFOs.
REQ-011 SHALL have port pkt_done_o  output  1  one-cycle pulse on acceptance of a packet's last byte.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse on parity mismatch.

Function
REQ-013 Packet format SHALL be: header byte (bits [1:0] destination, bits [7:2] payload length L, 0..63), L payload bytes, then one parity byte when PARITY_CHECK_EN is defined.
REQ-014 FSM SHALL have states IDLE, PAYLOAD, PARITY; IDLE->PAYLOAD on header accept with L>0; IDLE->PARITY (or stay IDLE without macro) on header accept with L=0; PAYLOAD->PARITY (or IDLE) on accept of last payload byte; PARITY->IDLE on parity byte accept.
REQ-015 In IDLE, ready_o SHALL equal !fifo_full_i[data_i[1:0]]; in PAYLOAD/PARITY, ready_o SHALL equal !fifo_full_i[dest_q].
REQ-016 dest_q and a 6-bit down-counter SHALL be loaded from the header on header accept; counter decrements per accepted payload byte.
REQ-017 Every accepted byte (header, payload, parity) SHALL be forwarded combinationally: wr_o = one-hot(dest) when accepted else 0, wr_data_o = data_i; zero latency.
REQ-018 No wr_o bit SHALL assert while the corresponding fifo_full_i bit is high.
REQ-019 pkt_valid_i low mid-packet SHALL stall without abort; state, counter and parity accumulator hold.
REQ-020 Full asserting mid-packet SHALL stall (ready_o=0) until it clears; no byte lost or duplicated.
REQ-021 Running parity SHALL be XOR of header and all payload bytes; cleared on return to IDLE.
REQ-022 pkt_done_o SHALL pulse in the cycle the final byte (parity byte, or last payload/header without macro) is accepted.

Reset
REQ-023 On rst_ni low, state SHALL be IDLE, counter, dest_q and parity accumulator 0; pkt_done_o and err_o 0; wr_o 0.
REQ-024 Reset mid-packet SHALL discard the remainder; the next accepted byte after release SHALL be treated as a header.

Configuration
REQ-025 Macro PKT_DEMUX_PARITY_CHECK_EN defined: PARITY state exists, parity byte expected, forwarded, compared; err_o pulses with pkt_done_o on mismatch.
REQ-026 Macro undefined: no PARITY state or accumulator; packet ends after last payload byte; err_o tied 0.

Structure
REQ-027 Package router_pkg SHALL hold N_PORTS, DATA_W, LEN_W=6, the FSM state enum typedef and a packed header struct typedef (len, dest).
REQ-028 No sub-module; FSM, counter and parity accumulator SHALL be in one module.

Verification
REQ-029 Header 0x0D (dest 1, L=3), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D -> four wr_o=4'b0010 writes then parity write, pkt_done_o pulse, err_o=0.
REQ-030 Same packet with parity 0x00 -> pkt_done_o and err_o pulse same cycle; all 5 bytes written.
REQ-031 fifo_full_i[2]=1 while header 0x06 presented -> ready_o=0, wr_o=0; full drops -> header accepted next cycle.
REQ-032 Header 0x00 (dest 0, L=0) -> with macro, next byte treated as parity; without macro, pkt_done_o pulses on header, FSM stays IDLE.
REQ-033 rst_ni pulsed after 2 payload bytes of L=5 packet -> state IDLE; next byte 0x07 decoded as header to dest 3.
REQ-034 pkt_valid_i toggled every cycle during L=63 packet -> exactly 63 payload writes to one destination, counter reaches 0, pkt_done_o once.

Source files
------------

// File: rtl/pkt_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg (package)
// Purpose  : Shared constants, FSM state type and header layout for the
//            packet demultiplexer.
// Contents : N_PORTS, DATA_W, LEN_W, DEST_W, state_t, hdr_t
// Config   : PKT_DEMUX_PARITY_CHECK_EN adds the PARITY state
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int N_PORTS = 4;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 6;
    localparam int DEST_W  = $clog2(N_PORTS);

`ifdef PKT_DEMUX_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1
    } state_t;
`endif

    // Header byte: [7:2] payload length, [1:0] destination.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DEST_W-1:0] dest;
    } hdr_t;

endpackage
`default_nettype wire

// File: rtl/pkt_demux.sv
`default_nettype none
// ============================================================================
// Module   : pkt_demux
// Purpose  : Routes a length-prefixed byte stream to one of N_PORTS FIFOs.
//            The header selects the destination; every accepted byte is
//            forwarded to that FIFO with zero latency.
// Ports    : clk_i, rst_ni (async, active-low)
//            pkt_valid_i, data_i, ready_o    - upstream byte handshake
//            fifo_full_i                     - per-destination full flags
//            wr_o, wr_data_o                 - one-hot write strobe + data
//            pkt_done_o, err_o               - last-byte / parity-error pulses
// Config   : PKT_DEMUX_PARITY_CHECK_EN - trailing parity byte checked
// Revision : 1.0 - initial release
// ============================================================================
module pkt_demux
    import router_pkg::*;
#(
    parameter int N_PORTS = router_pkg::N_PORTS,
    parameter int DATA_W  = router_pkg::DATA_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pkt_valid_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               ready_o,
    input  logic [N_PORTS-1:0] fifo_full_i,
    output logic [N_PORTS-1:0] wr_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic               pkt_done_o,
    output logic               err_o
);

    state_t            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DEST_W-1:0] dest_q;
`ifdef PKT_DEMUX_PARITY_CHECK_EN
    logic [DATA_W-1:0] par_q;
`endif

    hdr_t              hdr;
    logic [DEST_W-1:0] cur_dest;
    logic              accept;
    logic              last_byte;
    logic              par_bad;

    assign hdr = hdr_t'(data_i[LEN_W+DEST_W-1:0]);

    always_comb begin
        // In IDLE the incoming byte is the header, so it routes itself.
        cur_dest  = (state_q == IDLE) ? hdr.dest : dest_q;
        ready_o   = !fifo_full_i[cur_dest];
        // Gating with rst_ni keeps strobes quiet while reset is held.
        accept    = pkt_valid_i && ready_o && rst_ni;
        wr_o      = accept ? (N_PORTS'(1) << cur_dest) : '0;
        wr_data_o = data_i;
        last_byte = 1'b0;
        par_bad   = 1'b0;
        case (state_q)
`ifdef PKT_DEMUX_PARITY_CHECK_EN
            IDLE:    last_byte = 1'b0;
            PAYLOAD: last_byte = 1'b0;
            PARITY: begin
                last_byte = 1'b1;
                par_bad   = (par_q != data_i);
            end
`else
            IDLE:    last_byte = (hdr.len == '0);
            PAYLOAD: last_byte = (cnt_q == LEN_W'(1));
`endif
            default: last_byte = 1'b0;
        endcase
        pkt_done_o = accept && last_byte;
        err_o      = accept && par_bad;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
`ifdef PKT_DEMUX_PARITY_CHECK_EN
            par_q   <= '0;
`endif
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    dest_q <= hdr.dest;
                    cnt_q  <= hdr.len;
`ifdef PKT_DEMUX_PARITY_CHECK_EN
                    par_q  <= data_i;
                    state_q <= (hdr.len != '0) ? PAYLOAD : PARITY;
`else
                    state_q <= (hdr.len != '0) ? PAYLOAD : IDLE;
`endif
                end
                PAYLOAD: begin
                    cnt_q <= cnt_q - LEN_W'(1);
`ifdef PKT_DEMUX_PARITY_CHECK_EN
                    par_q <= par_q ^ data_i;
                    if (cnt_q == LEN_W'(1)) state_q <= PARITY;
`else
                    if (cnt_q == LEN_W'(1)) state_q <= IDLE;
`endif
                end
`ifdef PKT_DEMUX_PARITY_CHECK_EN
                PARITY: begin
                    par_q   <= '0;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_demux
// Purpose  : Self-checking bench for pkt_demux. A packet-level model
//            (bytes remaining, destination, running XOR) predicts the
//            outputs every cycle; directed packets pin literal values.
// Config   : PKT_DEMUX_PARITY_CHECK_EN selects the parity-byte format
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_demux;

`ifdef PKT_DEMUX_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       pkt_valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       ready_o;
    logic [3:0] fifo_full_i = 4'h0;
    logic [3:0] wr_o;
    logic [7:0] wr_data_o;
    logic       pkt_done_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    pkt_demux dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pkt_valid_i (pkt_valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .fifo_full_i (fifo_full_i),
        .wr_o        (wr_o),
        .wr_data_o   (wr_data_o),
        .pkt_done_o  (pkt_done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- packet-level model ----------------
    bit       m_in_pkt = 0;
    int       m_rem    = 0;   // bytes still owed after the header
    bit [1:0] m_dest   = 0;
    bit [7:0] m_xor    = 0;
    int       wr_cnt [4];
    int       done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial for (int i = 0; i < 4; i++) wr_cnt[i] = 0;

    always @(negedge clk_i) begin
        bit [1:0] d;
        bit       acc, done, err;
        bit [3:0] ewr;
        if (!rst_ni) begin
            m_in_pkt = 0; m_rem = 0; m_xor = 0;
        end
        d    = m_in_pkt ? m_dest : data_i[1:0];
        acc  = pkt_valid_i && !fifo_full_i[d] && rst_ni;
        done = 0;
        err  = 0;
        if (acc) begin
            if (!m_in_pkt) begin
                m_rem = int'(data_i[7:2]) + PAR;
                if (m_rem == 0) done = 1;
                else begin
                    m_in_pkt = 1; m_dest = d; m_xor = data_i;
                end
            end else begin
                if (PAR == 1 && m_rem == 1) err = (m_xor != data_i);
                else m_xor = m_xor ^ data_i;
                m_rem--;
                if (m_rem == 0) begin
                    m_in_pkt = 0; done = 1;
                end
            end
        end
        ewr = acc ? (4'b0001 << d) : 4'b0000;
        check("ready", int'(ready_o), int'(!fifo_full_i[d]));
        check("wr", int'(wr_o), int'(ewr));
        if (acc) check("wr_data", int'(wr_data_o), int'(data_i));
        check("pkt_done", int'(pkt_done_o), int'(done));
        check("err", int'(err_o), int'(err));
        if ((wr_o & fifo_full_i) != 4'h0) check("wr_while_full", 1, 0);
        for (int i = 0; i < 4; i++) if (wr_o[i]) wr_cnt[i]++;
        if (pkt_done_o) done_cnt++;
    end

    // ---------------- driver ----------------
    bit rand_full = 0;

    task automatic send(input bit [7:0] b, output bit [3:0] w,
                        output bit dn, output bit er);
        pkt_valid_i = 1'b1;
        data_i      = b;
        w = 0; dn = 0; er = 0;
        for (int k = 0; k < 300; k++) begin
            if (rand_full) fifo_full_i = 4'($urandom & $urandom);
            @(negedge clk_i);
            if (ready_o) begin
                w = wr_o; dn = pkt_done_o; er = err_o;
                @(posedge clk_i); #1;
                pkt_valid_i = 1'b0;
                fifo_full_i = 4'h0;
                return;
            end
            @(posedge clk_i); #1;
        end
        check("send_timeout", 0, 1);
        pkt_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        pkt_valid_i = 1'b0;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        bit [3:0] w;
        bit dn, er;
        bit [7:0] pl [$];
        bit [7:0] x;
        int dc0, wc0;

        // Reset state
        #2;
        check("reset_wr", int'(wr_o), 0);
        check("reset_done", int'(pkt_done_o), 0);
        check("reset_err", int'(err_o), 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle(1);

        // Header 0x0D: dest 1, three payload bytes, correct parity 0x0D
        send(8'h0D, w, dn, er); check("p1_hdr_wr", int'(w), 4'b0010); check("p1_hdr_done", int'(dn), 0);
        send(8'h11, w, dn, er); check("p1_b1_wr", int'(w), 4'b0010);
        send(8'h22, w, dn, er); check("p1_b2_wr", int'(w), 4'b0010);
        send(8'h33, w, dn, er); check("p1_b3_wr", int'(w), 4'b0010); check("p1_b3_done", int'(dn), 1 - PAR);
        if (PAR == 1) begin
            send(8'h0D, w, dn, er);
            check("p1_par_wr", int'(w), 4'b0010);
            check("p1_par_done", int'(dn), 1);
            check("p1_par_err", int'(er), 0);
            // Same packet with wrong parity
            send(8'h0D, w, dn, er); send(8'h11, w, dn, er);
            send(8'h22, w, dn, er); send(8'h33, w, dn, er);
            send(8'h00, w, dn, er);
            check("p2_par_wr", int'(w), 4'b0010);
            check("p2_par_done", int'(dn), 1);
            check("p2_par_err", int'(er), 1);
        end

        // Full destination stalls the header 0x06 (dest 2, L=1)
        fifo_full_i = 4'b0100; pkt_valid_i = 1'b1; data_i = 8'h06;
        @(negedge clk_i);
        check("full_ready", int'(ready_o), 0);
        check("full_wr", int'(wr_o), 0);
        @(posedge clk_i); #1; fifo_full_i = 4'b0000;
        @(negedge clk_i);
        check("unfull_wr", int'(wr_o), 4'b0100);
        @(posedge clk_i); #1; pkt_valid_i = 1'b0;
        send(8'hA5, w, dn, er); check("full_pl_wr", int'(w), 4'b0100);
        if (PAR == 1) begin send(8'hA3, w, dn, er); check("full_par_err", int'(er), 0); end

        // Zero-length header
        send(8'h00, w, dn, er);
        check("l0_hdr_wr", int'(w), 4'b0001);
        check("l0_hdr_done", int'(dn), 1 - PAR);
        if (PAR == 1) begin
            send(8'h00, w, dn, er);
            check("l0_par_done", int'(dn), 1); check("l0_par_err", int'(er), 0);
        end

        // Reset after two payload bytes of an L=5 packet to dest 0
        send(8'h14, w, dn, er); send(8'h01, w, dn, er); send(8'h02, w, dn, er);
        rst_ni = 1'b0; idle(1); rst_ni = 1'b1; idle(1);
        send(8'h07, w, dn, er);
        check("rst_hdr_wr", int'(w), 4'b1000);
        check("rst_hdr_done", int'(dn), 0);
        send(8'h55, w, dn, er); check("rst_pl_done", int'(dn), 1 - PAR);
        if (PAR == 1) send(8'h07 ^ 8'h55, w, dn, er);

        // L=63 packet to dest 2 with valid toggling every cycle
        dc0 = done_cnt; wc0 = wr_cnt[2];
        x = 8'hFE;
        send(8'hFE, w, dn, er);
        for (int i = 0; i < 63; i++) begin
            bit [7:0] b;
            b = 8'($urandom);
            x ^= b;
            idle(1);
            send(b, w, dn, er);
        end
        if (PAR == 1) begin idle(1); send(x, w, dn, er); check("l63_err", int'(er), 0); end
        check("l63_writes", wr_cnt[2] - wc0, 64 + PAR);
        check("l63_done", done_cnt - dc0, 1);

        // Randomized packets with random gaps, full flags and parity errors
        rand_full = 1;
        for (int p = 0; p < 40; p++) begin
            bit [7:0] h;
            h = {6'($urandom_range(0, 12)), 2'($urandom)};
            x = h;
            idle($urandom_range(0, 2));
            send(h, w, dn, er);
            for (int i = 0; i < int'(h[7:2]); i++) begin
                bit [7:0] b;
                b = 8'($urandom);
                x ^= b;
                idle($urandom_range(0, 1));
                send(b, w, dn, er);
            end
            if (PAR == 1) begin
                if ($urandom_range(0, 3) == 0) x = ~x;
                send(x, w, dn, er);
            end
        end
        rand_full = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
